ddr3_axi_arbiter: RTL and testbench

Two-master AXI4 arbiter placed in front of the DDR3 controller's AXI slave port (upstream of the retime stage), sharing that single port between port 0 (CPU) and port 1 (accelerator DMA). Read and write paths arbitrate independently. Each path locks to one master for a whole burst, from address handshake to final response, so responses need no ID-based routing. The arbitration policy is round-robin or fixed-priority, selected at compile time.

---
 rtl/ddr3_axi_arbiter.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ddr3_axi_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_axi_arbiter.sv
// Two-master AXI4 arbiter sharing the DDR3 controller AXI port; read and write paths each lock to one master per burst.
// Define DDR3_AXI_ARB_RR_EN for round-robin arbitration; left undefined, port 0 has fixed priority.
// Valid/ready: a beat transfers on a rising edge where valid and ready are both high; the source holds valid and payload stable until then, and this block only steers those signals combinationally, never registering a beat.
module ddr3_axi_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport0_awvalid_i,
  input  logic [31:0] inport0_awaddr_i,
  input  logic [4:0]  inport0_awid_i,
  input  logic [7:0]  inport0_awlen_i,
  input  logic [1:0]  inport0_awburst_i,
  output logic        inport0_awready_o,
  input  logic        inport0_wvalid_i,
  input  logic [31:0] inport0_wdata_i,
  input  logic [3:0]  inport0_wstrb_i,
  input  logic        inport0_wlast_i,
  output logic        inport0_wready_o,
  output logic        inport0_bvalid_o,
  output logic [1:0]  inport0_bresp_o,
  output logic [4:0]  inport0_bid_o,
  input  logic        inport0_bready_i,
  input  logic        inport0_arvalid_i,
  input  logic [31:0] inport0_araddr_i,
  input  logic [4:0]  inport0_arid_i,
  input  logic [7:0]  inport0_arlen_i,
  input  logic [1:0]  inport0_arburst_i,
  output logic        inport0_arready_o,
  output logic        inport0_rvalid_o,
  output logic [31:0] inport0_rdata_o,
  output logic [1:0]  inport0_rresp_o,
  output logic [4:0]  inport0_rid_o,
  output logic        inport0_rlast_o,
  input  logic        inport0_rready_i,
  input  logic        inport1_awvalid_i,
  input  logic [31:0] inport1_awaddr_i,
  input  logic [4:0]  inport1_awid_i,
  input  logic [7:0]  inport1_awlen_i,
  input  logic [1:0]  inport1_awburst_i,
  output logic        inport1_awready_o,
  input  logic        inport1_wvalid_i,
  input  logic [31:0] inport1_wdata_i,
  input  logic [3:0]  inport1_wstrb_i,
  input  logic        inport1_wlast_i,
  output logic        inport1_wready_o,
  output logic        inport1_bvalid_o,
  output logic [1:0]  inport1_bresp_o,
  output logic [4:0]  inport1_bid_o,
  input  logic        inport1_bready_i,
  input  logic        inport1_arvalid_i,
  input  logic [31:0] inport1_araddr_i,
  input  logic [4:0]  inport1_arid_i,
  input  logic [7:0]  inport1_arlen_i,
  input  logic [1:0]  inport1_arburst_i,
  output logic        inport1_arready_o,
  output logic        inport1_rvalid_o,
  output logic [31:0] inport1_rdata_o,
  output logic [1:0]  inport1_rresp_o,
  output logic [4:0]  inport1_rid_o,
  output logic        inport1_rlast_o,
  input  logic        inport1_rready_i,
  output logic        outport_awvalid_o,
  output logic [31:0] outport_awaddr_o,
  output logic [4:0]  outport_awid_o,
  output logic [7:0]  outport_awlen_o,
  output logic [1:0]  outport_awburst_o,
  input  logic        outport_awready_i,
  output logic        outport_wvalid_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  output logic        outport_wlast_o,
  input  logic        outport_wready_i,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  input  logic [4:0]  outport_bid_i,
  output logic        outport_bready_o,
  output logic        outport_arvalid_o,
  output logic [31:0] outport_araddr_o,
  output logic [4:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  input  logic        outport_arready_i,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [4:0]  outport_rid_i,
  input  logic        outport_rlast_i,
  output logic        outport_rready_o,
  output logic [1:0]  dbg_wr_state_o,
  output logic [1:0]  dbg_rd_state_o
);

  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_ACTIVE = 2'd1, WR_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_DATA = 2'd2} rd_state_t;

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;
  logic      wr_grant_q, rd_grant_q;
  logic      aw_done_q, w_done_q;
  logic      wr_req, rd_req, wr_pick, rd_pick;
  logic      aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;
  logic      sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;

  assign wr_req = inport0_awvalid_i | inport1_awvalid_i;
  assign rd_req = inport0_arvalid_i | inport1_arvalid_i;

`ifdef DDR3_AXI_ARB_RR_EN
  // last_*_q holds the most recent winner; on contention the other port wins.
  logic last_wr_q, last_rd_q;

  assign wr_pick = (inport0_awvalid_i & inport1_awvalid_i) ? ~last_wr_q : inport1_awvalid_i;
  assign rd_pick = (inport0_arvalid_i & inport1_arvalid_i) ? ~last_rd_q : inport1_arvalid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_wr_q <= 1'b1;
      last_rd_q <= 1'b1;
    end else begin
      if (wr_state_q == WR_IDLE && wr_req) last_wr_q <= wr_pick;
      if (rd_state_q == RD_IDLE && rd_req) last_rd_q <= rd_pick;
    end
  end
`else
  assign wr_pick = ~inport0_awvalid_i;
  assign rd_pick = ~inport0_arvalid_i;
`endif

  // Granted-master request signals and outport payload muxes.
  assign sel_awvalid = wr_grant_q ? inport1_awvalid_i : inport0_awvalid_i;
  assign sel_wvalid  = wr_grant_q ? inport1_wvalid_i  : inport0_wvalid_i;
  assign sel_bready  = wr_grant_q ? inport1_bready_i  : inport0_bready_i;
  assign sel_arvalid = rd_grant_q ? inport1_arvalid_i : inport0_arvalid_i;
  assign sel_rready  = rd_grant_q ? inport1_rready_i  : inport0_rready_i;

  assign outport_awaddr_o  = wr_grant_q ? inport1_awaddr_i  : inport0_awaddr_i;
  assign outport_awid_o    = wr_grant_q ? inport1_awid_i    : inport0_awid_i;
  assign outport_awlen_o   = wr_grant_q ? inport1_awlen_i   : inport0_awlen_i;
  assign outport_awburst_o = wr_grant_q ? inport1_awburst_i : inport0_awburst_i;
  assign outport_wdata_o   = wr_grant_q ? inport1_wdata_i   : inport0_wdata_i;
  assign outport_wstrb_o   = wr_grant_q ? inport1_wstrb_i   : inport0_wstrb_i;
  assign outport_wlast_o   = wr_grant_q ? inport1_wlast_i   : inport0_wlast_i;
  assign outport_araddr_o  = rd_grant_q ? inport1_araddr_i  : inport0_araddr_i;
  assign outport_arid_o    = rd_grant_q ? inport1_arid_i    : inport0_arid_i;
  assign outport_arlen_o   = rd_grant_q ? inport1_arlen_i   : inport0_arlen_i;
  assign outport_arburst_o = rd_grant_q ? inport1_arburst_i : inport0_arburst_i;

  // Response payloads go to both masters; only the valid is steered.
  assign inport0_bresp_o = outport_bresp_i;
  assign inport0_bid_o   = outport_bid_i;
  assign inport1_bresp_o = outport_bresp_i;
  assign inport1_bid_o   = outport_bid_i;
  assign inport0_rdata_o = outport_rdata_i;
  assign inport0_rresp_o = outport_rresp_i;
  assign inport0_rid_o   = outport_rid_i;
  assign inport0_rlast_o = outport_rlast_i;
  assign inport1_rdata_o = outport_rdata_i;
  assign inport1_rresp_o = outport_rresp_i;
  assign inport1_rid_o   = outport_rid_i;
  assign inport1_rlast_o = outport_rlast_i;

  assign aw_hs     = outport_awvalid_o & outport_awready_i;
  assign w_last_hs = outport_wvalid_o & outport_wready_i & outport_wlast_o;
  assign b_hs      = outport_bvalid_i & outport_bready_o;
  assign ar_hs     = outport_arvalid_o & outport_arready_i;
  assign r_last_hs = outport_rvalid_i & outport_rready_o & outport_rlast_i;

  assign dbg_wr_state_o = wr_state_q;
  assign dbg_rd_state_o = rd_state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE:   if (wr_req) wr_state_d = WR_ACTIVE;
      WR_ACTIVE: if ((aw_done_q | aw_hs) & (w_done_q | w_last_hs)) wr_state_d = WR_RESP;
      WR_RESP:   if (b_hs) wr_state_d = WR_IDLE;
      default:   wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: if (rd_req) rd_state_d = RD_ADDR;
      RD_ADDR: if (ar_hs) rd_state_d = RD_DATA;
      RD_DATA: if (r_last_hs) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Channel valid/ready steering; AW and W stop forwarding once their own handshake is done.
  always_comb begin
    outport_awvalid_o = 1'b0;
    outport_wvalid_o  = 1'b0;
    outport_bready_o  = 1'b0;
    outport_arvalid_o = 1'b0;
    outport_rready_o  = 1'b0;
    inport0_awready_o = 1'b0;
    inport0_wready_o  = 1'b0;
    inport0_bvalid_o  = 1'b0;
    inport0_arready_o = 1'b0;
    inport0_rvalid_o  = 1'b0;
    inport1_awready_o = 1'b0;
    inport1_wready_o  = 1'b0;
    inport1_bvalid_o  = 1'b0;
    inport1_arready_o = 1'b0;
    inport1_rvalid_o  = 1'b0;
    if (wr_state_q == WR_ACTIVE) begin
      outport_awvalid_o = sel_awvalid & ~aw_done_q;
      outport_wvalid_o  = sel_wvalid & ~w_done_q;
      inport0_awready_o = ~wr_grant_q & ~aw_done_q & outport_awready_i;
      inport1_awready_o = wr_grant_q & ~aw_done_q & outport_awready_i;
      inport0_wready_o  = ~wr_grant_q & ~w_done_q & outport_wready_i;
      inport1_wready_o  = wr_grant_q & ~w_done_q & outport_wready_i;
    end
    if (wr_state_q == WR_RESP) begin
      outport_bready_o = sel_bready;
      inport0_bvalid_o = ~wr_grant_q & outport_bvalid_i;
      inport1_bvalid_o = wr_grant_q & outport_bvalid_i;
    end
    if (rd_state_q == RD_ADDR) begin
      outport_arvalid_o = sel_arvalid;
      inport0_arready_o = ~rd_grant_q & outport_arready_i;
      inport1_arready_o = rd_grant_q & outport_arready_i;
    end
    if (rd_state_q == RD_DATA) begin
      outport_rready_o = sel_rready;
      inport0_rvalid_o = ~rd_grant_q & outport_rvalid_i;
      inport1_rvalid_o = rd_grant_q & outport_rvalid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_grant_q <= 1'b0;
      rd_grant_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      if (wr_state_q == WR_IDLE && wr_req) wr_grant_q <= wr_pick;
      if (rd_state_q == RD_IDLE && rd_req) rd_grant_q <= rd_pick;
      if (b_hs) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs)     aw_done_q <= 1'b1;
        if (w_last_hs) w_done_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_axi_arbiter.sv
// Directed bench for ddr3_axi_arbiter: the bench plays both masters and the DDR3 slave.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ddr3_axi_arbiter;

  localparam logic [1:0] WR_IDLE = 2'd0, WR_ACTIVE = 2'd1, WR_RESP = 2'd2;
  localparam logic [1:0] RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_DATA = 2'd2;

  logic clk_i, rst_i;
  logic inport0_awvalid_i, inport0_awready_o, inport0_wvalid_i, inport0_wlast_i, inport0_wready_o;
  logic inport0_bvalid_o, inport0_bready_i, inport0_arvalid_i, inport0_arready_o;
  logic inport0_rvalid_o, inport0_rlast_o, inport0_rready_i;
  logic [31:0] inport0_awaddr_i, inport0_wdata_i, inport0_araddr_i, inport0_rdata_o;
  logic [4:0] inport0_awid_i, inport0_bid_o, inport0_arid_i, inport0_rid_o;
  logic [7:0] inport0_awlen_i, inport0_arlen_i;
  logic [1:0] inport0_awburst_i, inport0_bresp_o, inport0_arburst_i, inport0_rresp_o;
  logic [3:0] inport0_wstrb_i;
  logic inport1_awvalid_i, inport1_awready_o, inport1_wvalid_i, inport1_wlast_i, inport1_wready_o;
  logic inport1_bvalid_o, inport1_bready_i, inport1_arvalid_i, inport1_arready_o;
  logic inport1_rvalid_o, inport1_rlast_o, inport1_rready_i;
  logic [31:0] inport1_awaddr_i, inport1_wdata_i, inport1_araddr_i, inport1_rdata_o;
  logic [4:0] inport1_awid_i, inport1_bid_o, inport1_arid_i, inport1_rid_o;
  logic [7:0] inport1_awlen_i, inport1_arlen_i;
  logic [1:0] inport1_awburst_i, inport1_bresp_o, inport1_arburst_i, inport1_rresp_o;
  logic [3:0] inport1_wstrb_i;
  logic outport_awvalid_o, outport_awready_i, outport_wvalid_o, outport_wlast_o, outport_wready_i;
  logic outport_bvalid_i, outport_bready_o, outport_arvalid_o, outport_arready_i;
  logic outport_rvalid_i, outport_rlast_i, outport_rready_o;
  logic [31:0] outport_awaddr_o, outport_wdata_o, outport_araddr_o, outport_rdata_i;
  logic [4:0] outport_awid_o, outport_bid_i, outport_arid_o, outport_rid_i;
  logic [7:0] outport_awlen_o, outport_arlen_o;
  logic [1:0] outport_awburst_o, outport_bresp_i, outport_arburst_o, outport_rresp_i;
  logic [3:0] outport_wstrb_o;
  logic [1:0] dbg_wr_state_o, dbg_rd_state_o;

  logic [14:0] vr_all;
  logic [31:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  assign vr_all = {outport_awvalid_o, outport_wvalid_o, outport_bready_o, outport_arvalid_o, outport_rready_o,
                   inport0_awready_o, inport0_wready_o, inport0_bvalid_o, inport0_arready_o, inport0_rvalid_o,
                   inport1_awready_o, inport1_wready_o, inport1_bvalid_o, inport1_arready_o, inport1_rvalid_o};

  ddr3_axi_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inport0_awvalid_i(inport0_awvalid_i), .inport0_awaddr_i(inport0_awaddr_i), .inport0_awid_i(inport0_awid_i),
    .inport0_awlen_i(inport0_awlen_i), .inport0_awburst_i(inport0_awburst_i), .inport0_awready_o(inport0_awready_o),
    .inport0_wvalid_i(inport0_wvalid_i), .inport0_wdata_i(inport0_wdata_i), .inport0_wstrb_i(inport0_wstrb_i),
    .inport0_wlast_i(inport0_wlast_i), .inport0_wready_o(inport0_wready_o),
    .inport0_bvalid_o(inport0_bvalid_o), .inport0_bresp_o(inport0_bresp_o), .inport0_bid_o(inport0_bid_o),
    .inport0_bready_i(inport0_bready_i),
    .inport0_arvalid_i(inport0_arvalid_i), .inport0_araddr_i(inport0_araddr_i), .inport0_arid_i(inport0_arid_i),
    .inport0_arlen_i(inport0_arlen_i), .inport0_arburst_i(inport0_arburst_i), .inport0_arready_o(inport0_arready_o),
    .inport0_rvalid_o(inport0_rvalid_o), .inport0_rdata_o(inport0_rdata_o), .inport0_rresp_o(inport0_rresp_o),
    .inport0_rid_o(inport0_rid_o), .inport0_rlast_o(inport0_rlast_o), .inport0_rready_i(inport0_rready_i),
    .inport1_awvalid_i(inport1_awvalid_i), .inport1_awaddr_i(inport1_awaddr_i), .inport1_awid_i(inport1_awid_i),
    .inport1_awlen_i(inport1_awlen_i), .inport1_awburst_i(inport1_awburst_i), .inport1_awready_o(inport1_awready_o),
    .inport1_wvalid_i(inport1_wvalid_i), .inport1_wdata_i(inport1_wdata_i), .inport1_wstrb_i(inport1_wstrb_i),
    .inport1_wlast_i(inport1_wlast_i), .inport1_wready_o(inport1_wready_o),
    .inport1_bvalid_o(inport1_bvalid_o), .inport1_bresp_o(inport1_bresp_o), .inport1_bid_o(inport1_bid_o),
    .inport1_bready_i(inport1_bready_i),
    .inport1_arvalid_i(inport1_arvalid_i), .inport1_araddr_i(inport1_araddr_i), .inport1_arid_i(inport1_arid_i),
    .inport1_arlen_i(inport1_arlen_i), .inport1_arburst_i(inport1_arburst_i), .inport1_arready_o(inport1_arready_o),
    .inport1_rvalid_o(inport1_rvalid_o), .inport1_rdata_o(inport1_rdata_o), .inport1_rresp_o(inport1_rresp_o),
    .inport1_rid_o(inport1_rid_o), .inport1_rlast_o(inport1_rlast_o), .inport1_rready_i(inport1_rready_i),
    .outport_awvalid_o(outport_awvalid_o), .outport_awaddr_o(outport_awaddr_o), .outport_awid_o(outport_awid_o),
    .outport_awlen_o(outport_awlen_o), .outport_awburst_o(outport_awburst_o), .outport_awready_i(outport_awready_i),
    .outport_wvalid_o(outport_wvalid_o), .outport_wdata_o(outport_wdata_o), .outport_wstrb_o(outport_wstrb_o),
    .outport_wlast_o(outport_wlast_o), .outport_wready_i(outport_wready_i),
    .outport_bvalid_i(outport_bvalid_i), .outport_bresp_i(outport_bresp_i), .outport_bid_i(outport_bid_i),
    .outport_bready_o(outport_bready_o),
    .outport_arvalid_o(outport_arvalid_o), .outport_araddr_o(outport_araddr_o), .outport_arid_o(outport_arid_o),
    .outport_arlen_o(outport_arlen_o), .outport_arburst_o(outport_arburst_o), .outport_arready_i(outport_arready_i),
    .outport_rvalid_i(outport_rvalid_i), .outport_rdata_i(outport_rdata_i), .outport_rresp_i(outport_rresp_i),
    .outport_rid_i(outport_rid_i), .outport_rlast_i(outport_rlast_i), .outport_rready_o(outport_rready_o),
    .dbg_wr_state_o(dbg_wr_state_o), .dbg_rd_state_o(dbg_rd_state_o)
  );

  // Clock and reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  // Driver tasks
  task automatic idle_inputs();
    {inport0_awvalid_i, inport0_awaddr_i, inport0_awid_i, inport0_awlen_i, inport0_awburst_i} = '0;
    {inport0_wvalid_i, inport0_wdata_i, inport0_wstrb_i, inport0_wlast_i, inport0_bready_i} = '0;
    {inport0_arvalid_i, inport0_araddr_i, inport0_arid_i, inport0_arlen_i, inport0_arburst_i, inport0_rready_i} = '0;
    {inport1_awvalid_i, inport1_awaddr_i, inport1_awid_i, inport1_awlen_i, inport1_awburst_i} = '0;
    {inport1_wvalid_i, inport1_wdata_i, inport1_wstrb_i, inport1_wlast_i, inport1_bready_i} = '0;
    {inport1_arvalid_i, inport1_araddr_i, inport1_arid_i, inport1_arlen_i, inport1_arburst_i, inport1_rready_i} = '0;
    {outport_awready_i, outport_wready_i, outport_arready_i} = '0;
    {outport_bvalid_i, outport_bresp_i, outport_bid_i} = '0;
    {outport_rvalid_i, outport_rdata_i, outport_rresp_i, outport_rid_i, outport_rlast_i} = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    idle_inputs();
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    inport0_awvalid_i = 1'b1; inport0_awaddr_i = 32'h80;
    inport1_arvalid_i = 1'b1; inport1_araddr_i = 32'h90; inport1_arid_i = 5'h0a;
    {outport_awready_i, outport_wready_i, outport_arready_i, outport_bvalid_i, outport_rvalid_i} = 5'h1f;
    @(negedge clk_i); #1;
    checks++; if (vr_all !== 15'h0) begin errors++; $display("FAIL reset_vr: got %h expected 0", vr_all); end
    checks++; if ({dbg_wr_state_o, dbg_rd_state_o} !== {WR_IDLE, RD_IDLE})
      begin errors++; $display("FAIL reset_state: got %b expected 0000", {dbg_wr_state_o, dbg_rd_state_o}); end
    rst_i = 1'b0;
    {outport_awready_i, outport_wready_i, outport_arready_i, outport_bvalid_i, outport_rvalid_i} = 5'h0;
    @(negedge clk_i); #1;
    checks++; if ({outport_awvalid_o, outport_awaddr_o, outport_arvalid_o, outport_araddr_o, outport_arid_o} !==
                  {1'b1, 32'h80, 1'b1, 32'h90, 5'h0a})
      begin errors++; $display("FAIL post_reset_grant: got aw=%b %h ar=%b %h %h", outport_awvalid_o,
        outport_awaddr_o, outport_arvalid_o, outport_araddr_o, outport_arid_o); end
  endtask

  task automatic test_single_write();
    logic [31:0] exp;
    apply_reset();
    @(negedge clk_i);
    inport1_awvalid_i = 1'b1; inport1_awaddr_i = 32'h100; inport1_awid_i = 5'h05;
    inport1_awlen_i = 8'd3; inport1_awburst_i = 2'b01;
    #1;
    checks++; if ({outport_awvalid_o, inport1_awready_o} !== 2'b00)
      begin errors++; $display("FAIL wr_idle_aw: got %b expected 00", {outport_awvalid_o, inport1_awready_o}); end
    @(negedge clk_i);
    outport_awready_i = 1'b1; #1;
    checks++; if ({outport_awvalid_o, outport_awaddr_o, outport_awlen_o, outport_awid_o, inport1_awready_o, inport0_awready_o}
                  !== {1'b1, 32'h100, 8'd3, 5'h05, 1'b1, 1'b0})
      begin errors++; $display("FAIL wr_aw_fwd: got v=%b a=%h l=%h id=%h r1=%b r0=%b", outport_awvalid_o,
        outport_awaddr_o, outport_awlen_o, outport_awid_o, inport1_awready_o, inport0_awready_o); end
    @(negedge clk_i);
    inport1_awvalid_i = 1'b0; outport_awready_i = 1'b0; outport_wready_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      exp = 32'h1000 + b;
      inport1_wvalid_i = 1'b1; inport1_wdata_i = exp; inport1_wstrb_i = 4'hf; inport1_wlast_i = (b == 3);
      #1;
      checks++; if ({outport_wvalid_o, outport_wlast_o, outport_wdata_o, inport1_wready_o, outport_awvalid_o}
                    !== {1'b1, (b == 3), exp, 1'b1, 1'b0})
        begin errors++; $display("FAIL wr_beat%0d: got v=%b l=%b d=%h r=%b aw=%b expected d=%h", b, outport_wvalid_o,
          outport_wlast_o, outport_wdata_o, inport1_wready_o, outport_awvalid_o, exp); end
      @(negedge clk_i);
    end
    inport1_wvalid_i = 1'b0; inport1_wlast_i = 1'b0; outport_wready_i = 1'b0;
    outport_bvalid_i = 1'b1; outport_bid_i = 5'h05; outport_bresp_i = 2'b00; inport1_bready_i = 1'b1;
    #1;
    checks++; if (dbg_wr_state_o !== WR_RESP) begin errors++; $display("FAIL wr_resp_state: got %0d expected 2", dbg_wr_state_o); end
    checks++; if ({inport1_bvalid_o, inport1_bid_o, inport1_bresp_o, inport0_bvalid_o, inport0_rvalid_o, outport_bready_o}
                  !== {1'b1, 5'h05, 2'b00, 1'b0, 1'b0, 1'b1})
      begin errors++; $display("FAIL wr_b_route: got b1=%b id=%h resp=%h b0=%b r0=%b bready=%b", inport1_bvalid_o,
        inport1_bid_o, inport1_bresp_o, inport0_bvalid_o, inport0_rvalid_o, outport_bready_o); end
    @(negedge clk_i);
    outport_bvalid_i = 1'b0; inport1_bready_i = 1'b0; #1;
    checks++; if (dbg_wr_state_o !== WR_IDLE) begin errors++; $display("FAIL wr_done_idle: got %0d expected 0", dbg_wr_state_o); end
  endtask

  task automatic test_contention_read();
    apply_reset();
    @(negedge clk_i);
    inport0_arvalid_i = 1'b1; inport0_araddr_i = 32'h200; inport0_arid_i = 5'h01; inport0_arlen_i = 8'd1;
    inport1_arvalid_i = 1'b1; inport1_araddr_i = 32'h300; inport1_arid_i = 5'h02; inport1_arlen_i = 8'd0;
    @(negedge clk_i);
    outport_arready_i = 1'b1; #1;
    checks++; if ({outport_arvalid_o, outport_araddr_o, outport_arid_o, inport0_arready_o, inport1_arready_o}
                  !== {1'b1, 32'h200, 5'h01, 1'b1, 1'b0})
      begin errors++; $display("FAIL rd_first_grant: got v=%b a=%h id=%h r0=%b r1=%b", outport_arvalid_o,
        outport_araddr_o, outport_arid_o, inport0_arready_o, inport1_arready_o); end
    @(negedge clk_i);
    outport_arready_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      outport_rvalid_i = 1'b1; outport_rdata_i = 32'hd0 + b; outport_rid_i = 5'h01; outport_rlast_i = (b == 1);
      inport0_rready_i = 1'b1; #1;
      checks++; if ({inport0_rvalid_o, inport1_rvalid_o, inport0_rdata_o, outport_rready_o} !== {1'b1, 1'b0, 32'hd0 + b, 1'b1})
        begin errors++; $display("FAIL rd_beat%0d: got v0=%b v1=%b d=%h rr=%b", b, inport0_rvalid_o,
          inport1_rvalid_o, inport0_rdata_o, outport_rready_o); end
      @(negedge clk_i);
    end
    outport_rvalid_i = 1'b0; outport_rlast_i = 1'b0; inport0_rready_i = 1'b0; #1;
    checks++; if ({dbg_rd_state_o, outport_arvalid_o} !== {RD_IDLE, 1'b0})
      begin errors++; $display("FAIL rd_gap: got st=%0d arvalid=%b expected 0 0", dbg_rd_state_o, outport_arvalid_o); end
    @(negedge clk_i); #1;
`ifdef DDR3_AXI_ARB_RR_EN
    checks++; if ({outport_arvalid_o, outport_araddr_o, outport_arid_o} !== {1'b1, 32'h300, 5'h02})
      begin errors++; $display("FAIL rd_second_grant: got v=%b a=%h id=%h expected port 1", outport_arvalid_o,
        outport_araddr_o, outport_arid_o); end
`else
    checks++; if ({outport_arvalid_o, outport_araddr_o, outport_arid_o} !== {1'b1, 32'h200, 5'h01})
      begin errors++; $display("FAIL rd_second_grant: got v=%b a=%h id=%h expected port 0", outport_arvalid_o,
        outport_araddr_o, outport_arid_o); end
`endif
  endtask

  task automatic test_w_before_aw();
    apply_reset();
    @(negedge clk_i);
    inport0_wvalid_i = 1'b1; inport0_wdata_i = 32'ha5a5_0001; inport0_wstrb_i = 4'hf; inport0_wlast_i = 1'b1;
    outport_wready_i = 1'b1; #1;
    checks++; if ({outport_wvalid_o, inport0_wready_o} !== 2'b00)
      begin errors++; $display("FAIL wfirst_idle: got %b expected 00", {outport_wvalid_o, inport0_wready_o}); end
    @(negedge clk_i);
    @(negedge clk_i);
    inport0_awvalid_i = 1'b1; inport0_awaddr_i = 32'h40; inport0_awid_i = 5'h03; inport0_awlen_i = 8'd0;
    @(negedge clk_i); #1;
    checks++; if ({outport_wvalid_o, outport_wdata_o, inport0_wready_o, outport_awvalid_o} !== {1'b1, 32'ha5a5_0001, 1'b1, 1'b1})
      begin errors++; $display("FAIL wfirst_fwd: got wv=%b d=%h wr=%b awv=%b", outport_wvalid_o, outport_wdata_o,
        inport0_wready_o, outport_awvalid_o); end
    @(negedge clk_i);
    inport0_wvalid_i = 1'b0; inport0_wlast_i = 1'b0; outport_wready_i = 1'b0; #1;
    checks++; if ({dbg_wr_state_o, outport_wvalid_o} !== {WR_ACTIVE, 1'b0})
      begin errors++; $display("FAIL wfirst_wait_aw: got st=%0d wv=%b expected 1 0", dbg_wr_state_o, outport_wvalid_o); end
    outport_awready_i = 1'b1;
    @(negedge clk_i);
    inport0_awvalid_i = 1'b0; outport_awready_i = 1'b0;
    outport_bvalid_i = 1'b1; outport_bid_i = 5'h03; inport0_bready_i = 1'b1; #1;
    checks++; if ({dbg_wr_state_o, inport0_bvalid_o, inport0_bid_o, inport1_bvalid_o} !== {WR_RESP, 1'b1, 5'h03, 1'b0})
      begin errors++; $display("FAIL wfirst_resp: got st=%0d b0=%b id=%h b1=%b", dbg_wr_state_o, inport0_bvalid_o,
        inport0_bid_o, inport1_bvalid_o); end
    @(negedge clk_i);
    outport_bvalid_i = 1'b0; inport0_bready_i = 1'b0;
  endtask

  task automatic test_concurrent();
    apply_reset();
    @(negedge clk_i);
    inport0_arvalid_i = 1'b1; inport0_araddr_i = 32'h500; inport0_arid_i = 5'h04;
    inport1_awvalid_i = 1'b1; inport1_awaddr_i = 32'h600; inport1_awid_i = 5'h06;
    inport1_wvalid_i = 1'b1; inport1_wdata_i = 32'h1234; inport1_wlast_i = 1'b1; inport1_wstrb_i = 4'h3;
    {outport_awready_i, outport_wready_i, outport_arready_i} = 3'b111;
    @(negedge clk_i); #1;
    checks++; if ({outport_araddr_o, outport_awaddr_o, outport_wdata_o, outport_wstrb_o, inport0_arready_o,
                   inport1_awready_o, inport1_wready_o, inport0_awready_o, inport1_arready_o} !==
                  {32'h500, 32'h600, 32'h1234, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0})
      begin errors++; $display("FAIL conc_addr: got ar=%h aw=%h wd=%h rdy=%b", outport_araddr_o, outport_awaddr_o,
        outport_wdata_o, {inport0_arready_o, inport1_awready_o, inport1_wready_o, inport0_awready_o, inport1_arready_o}); end
    @(negedge clk_i);
    idle_inputs();
    outport_rvalid_i = 1'b1; outport_rdata_i = 32'hcafe; outport_rid_i = 5'h04; outport_rlast_i = 1'b1;
    outport_bvalid_i = 1'b1; outport_bid_i = 5'h06; outport_bresp_i = 2'b10;
    inport0_rready_i = 1'b1; inport1_bready_i = 1'b1; #1;
    checks++; if ({dbg_wr_state_o, dbg_rd_state_o} !== {WR_RESP, RD_DATA})
      begin errors++; $display("FAIL conc_state: got %b expected 1010", {dbg_wr_state_o, dbg_rd_state_o}); end
    checks++; if ({inport0_rvalid_o, inport1_rvalid_o, inport1_bvalid_o, inport0_bvalid_o, inport0_rdata_o,
                   inport1_bid_o, inport1_bresp_o} !== {4'b1010, 32'hcafe, 5'h06, 2'b10})
      begin errors++; $display("FAIL conc_route: got r0=%b r1=%b b1=%b b0=%b d=%h bid=%h", inport0_rvalid_o,
        inport1_rvalid_o, inport1_bvalid_o, inport0_bvalid_o, inport0_rdata_o, inport1_bid_o); end
    @(negedge clk_i);
    idle_inputs(); #1;
    checks++; if ({dbg_wr_state_o, dbg_rd_state_o} !== {WR_IDLE, RD_IDLE})
      begin errors++; $display("FAIL conc_done: got %b expected 0000", {dbg_wr_state_o, dbg_rd_state_o}); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    int beat, rbeat;
    bit aw_sent, done;
    apply_reset();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i));
    @(negedge clk_i);
    inport0_awvalid_i = 1'b1; inport0_awaddr_i = 32'h1000; inport0_awlen_i = 8'd15; inport0_awid_i = 5'h07;
    outport_awready_i = 1'b1;
    beat = 0; aw_sent = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk_i);
      if (dbg_wr_state_o === WR_RESP) done = 1'b1;
      else begin
        if (aw_sent) inport0_awvalid_i = 1'b0;
        inport0_wvalid_i = (beat < 16); inport0_wdata_i = 32'(beat); inport0_wlast_i = (beat == 15);
        inport0_wstrb_i = 4'hf;
        outport_wready_i = 1'($urandom_range(0, 1));
        #1;
        if (inport0_awvalid_i && inport0_awready_o) aw_sent = 1'b1;
        if (outport_wvalid_o && outport_wready_i) begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
          checks++; if ({outport_wdata_o, outport_wlast_o} !== {exp, exp == 32'd15})
            begin errors++; $display("FAIL bp_wbeat: got d=%h l=%b expected d=%h", outport_wdata_o, outport_wlast_o, exp); end
        end
        if (inport0_wvalid_i && inport0_wready_o) beat++;
      end
    end
    checks++; if (!done || exp_q.size() != 0)
      begin errors++; $display("FAIL bp_wr_end: got resp=%b left=%0d expected 1 0", done, exp_q.size()); end
    idle_inputs();
    outport_bvalid_i = 1'b1; outport_bid_i = 5'h07; inport0_bready_i = 1'b1;
    @(negedge clk_i);
    idle_inputs();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i));
    inport1_arvalid_i = 1'b1; inport1_araddr_i = 32'h2000; inport1_arlen_i = 8'd15; inport1_arid_i = 5'h09;
    outport_arready_i = 1'b1;
    @(negedge clk_i); #1;
    checks++; if (inport1_arready_o !== 1'b1) begin errors++; $display("FAIL bp_ar: got %b expected 1", inport1_arready_o); end
    @(negedge clk_i);
    inport1_arvalid_i = 1'b0; outport_arready_i = 1'b0;
    rbeat = 0;
    for (int cyc = 0; cyc < 300 && rbeat < 16; cyc++) begin
      outport_rvalid_i = 1'b1; outport_rdata_i = 32'(rbeat); outport_rlast_i = (rbeat == 15); outport_rid_i = 5'h09;
      inport1_rready_i = 1'($urandom_range(0, 1));
      #1;
      if (inport1_rvalid_o && inport1_rready_i) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
        checks++; if ({inport1_rdata_o, inport1_rlast_o, inport1_rid_o} !== {exp, exp == 32'd15, 5'h09})
          begin errors++; $display("FAIL bp_rbeat: got d=%h l=%b id=%h expected d=%h", inport1_rdata_o,
            inport1_rlast_o, inport1_rid_o, exp); end
      end
      if (outport_rvalid_i && outport_rready_o) rbeat++;
      @(negedge clk_i);
    end
    outport_rvalid_i = 1'b0; outport_rlast_i = 1'b0; inport1_rready_i = 1'b0; #1;
    checks++; if (rbeat != 16 || exp_q.size() != 0 || dbg_rd_state_o !== RD_IDLE)
      begin errors++; $display("FAIL bp_rd_end: got beats=%0d left=%0d st=%0d expected 16 0 0", rbeat,
        exp_q.size(), dbg_rd_state_o); end
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    @(negedge clk_i);
    inport0_arvalid_i = 1'b1; inport0_araddr_i = 32'h3000; inport0_arlen_i = 8'd7; inport0_arid_i = 5'h02;
    outport_arready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    inport0_arvalid_i = 1'b0; outport_arready_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      outport_rvalid_i = 1'b1; outport_rdata_i = 32'(b); outport_rid_i = 5'h02; inport0_rready_i = 1'b1;
      @(negedge clk_i);
    end
    outport_rdata_i = 32'd3;
    rst_i = 1'b1;
    @(negedge clk_i); #1;
    checks++; if (vr_all !== 15'h0) begin errors++; $display("FAIL midrst_vr: got %h expected 0", vr_all); end
    checks++; if ({dbg_wr_state_o, dbg_rd_state_o} !== {WR_IDLE, RD_IDLE})
      begin errors++; $display("FAIL midrst_state: got %b expected 0000", {dbg_wr_state_o, dbg_rd_state_o}); end
    rst_i = 1'b0; outport_rvalid_i = 1'b0; inport0_rready_i = 1'b0;
    inport1_arvalid_i = 1'b1; inport1_araddr_i = 32'h4000; inport1_arid_i = 5'h03; #1;
    checks++; if (outport_arvalid_o !== 1'b0) begin errors++; $display("FAIL midrst_t0: got %b expected 0", outport_arvalid_o); end
    @(negedge clk_i); #1;
    checks++; if ({outport_arvalid_o, outport_araddr_o, outport_arid_o} !== {1'b1, 32'h4000, 5'h03})
      begin errors++; $display("FAIL midrst_t1: got v=%b a=%h id=%h", outport_arvalid_o, outport_araddr_o, outport_arid_o); end
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_contention_read();
    test_w_before_aw();
    test_concurrent();
    test_backpressure();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
